// File: rtl/johnson_decoder.sv
// Receive-side decoder for a W-bit Johnson (twisted-ring) counter: validates the code word,
// converts it to a phase index, tracks sequence continuity with a HUNT/VERIFY/LOCKED machine.
module johnson_decoder #(
    parameter int W        = 8,
    parameter int IW       = 4,
    parameter int LOCK_CNT = 2,
    parameter int MISS_MAX = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  code,
    input  logic          code_valid,
    output logic [IW-1:0] index,
    output logic          index_valid,
    output logic          legal,
    output logic          locked,
    output logic          wrap,
    output logic          seq_err,
    output logic [7:0]    err_count
);

    localparam int SEQ_LEN = 2 * W;
    localparam int MCW     = $clog2(LOCK_CNT + 1);
    localparam int MSW     = $clog2(MISS_MAX + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t         state_q;
    logic [IW-1:0]  index_q;
    logic [IW-1:0]  expIdx_q;
    logic [MCW-1:0] matchCnt_q;
    logic [MSW-1:0] missCnt_q;
    logic           indexValid_q;
    logic           legal_q;
    logic           locked_q;
    logic           wrap_q;
    logic           seqErr_q;
    logic [7:0]     errCount_q;

    logic           decLegal_d;
    logic [IW-1:0]  decIdx_d;
    logic [IW-1:0]  decNext_d;
    logic [IW-1:0]  expNext_d;
    logic           inSeq_d;
    logic [MCW-1:0] matchInc_d;
    logic [MSW-1:0] missInc_d;

    function automatic logic [W-1:0] lowOnes(input int k);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < W; i++) begin
            m[i] = (i < k);
        end
        return m;
    endfunction

    function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] x);
        return (x == LAST_IDX) ? '0 : x + IW'(1);
    endfunction

    // Ones packed at the LSB end count up the first half; packed at the MSB end, the second half.
    always_comb begin
        decLegal_d = 1'b0;
        decIdx_d   = '0;
        for (int k = 0; k <= W; k++) begin
            if (code == lowOnes(k)) begin
                decLegal_d = 1'b1;
                decIdx_d   = IW'(k);
            end
        end
        for (int k = 1; k < W; k++) begin
            if (code == ~lowOnes(W - k)) begin
                decLegal_d = 1'b1;
                decIdx_d   = IW'(SEQ_LEN - k);
            end
        end
    end

    assign decNext_d  = nextIdx(decIdx_d);
    assign expNext_d  = nextIdx(expIdx_q);
    assign inSeq_d    = decLegal_d && (decIdx_d == expIdx_q);
    assign matchInc_d = matchCnt_q + MCW'(1);
    assign missInc_d  = missCnt_q + MSW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            index_q      <= '0;
            expIdx_q     <= '0;
            matchCnt_q   <= '0;
            missCnt_q    <= '0;
            indexValid_q <= 1'b0;
            legal_q      <= 1'b0;
            locked_q     <= 1'b0;
            wrap_q       <= 1'b0;
            seqErr_q     <= 1'b0;
            errCount_q   <= '0;
        end else begin
            indexValid_q <= code_valid;
            wrap_q       <= 1'b0;
            seqErr_q     <= 1'b0;
            if (code_valid) begin
                legal_q <= decLegal_d;
                if (decLegal_d) begin
                    index_q <= decIdx_d;
                end
                case (state_q)
                    HUNT: begin
                        if (decLegal_d) begin
                            expIdx_q   <= decNext_d;
                            matchCnt_q <= '0;
                            state_q    <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (!decLegal_d) begin
                            state_q <= HUNT;
                        end else if (inSeq_d) begin
                            expIdx_q   <= decNext_d;
                            matchCnt_q <= matchInc_d;
                            if (matchInc_d == MCW'(LOCK_CNT)) begin
                                state_q   <= LOCKED;
                                locked_q  <= 1'b1;
                                missCnt_q <= '0;
                            end
                        end else begin
                            expIdx_q   <= decNext_d;
                            matchCnt_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (inSeq_d) begin
                            expIdx_q  <= decNext_d;
                            missCnt_q <= '0;
                            wrap_q    <= (decIdx_d == '0);
                        end else begin
                            // An illegal code gives no new phase, so keep free-running the expectation.
                            expIdx_q  <= decLegal_d ? decNext_d : expNext_d;
                            seqErr_q  <= 1'b1;
                            missCnt_q <= missInc_d;
                            if (errCount_q != 8'hFF) begin
                                errCount_q <= errCount_q + 8'd1;
                            end
                            if (missInc_d == MSW'(MISS_MAX)) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign index       = index_q;
    assign index_valid = indexValid_q;
    assign legal       = legal_q;
    assign locked      = locked_q;
    assign wrap        = wrap_q;
    assign seq_err     = seqErr_q;
    assign err_count   = errCount_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: hand-written vector tables for the directed cases
// plus randomized traffic compared against a behavioural model of the decoder.
module tb_johnson_decoder;

    localparam int W        = 8;
    localparam int IW       = 4;
    localparam int LOCK_CNT = 2;
    localparam int MISS_MAX = 2;
    localparam int SEQ_LEN  = 2 * W;

    localparam int MODE_HUNT   = 0;
    localparam int MODE_VERIFY = 1;
    localparam int MODE_LOCKED = 2;

    logic          clk;
    logic          reset;
    logic [W-1:0]  code;
    logic          codeValid;
    logic [IW-1:0] index;
    logic          indexValid;
    logic          legal;
    logic          locked;
    logic          wrap;
    logic          seqErr;
    logic [7:0]    errCount;

    int checkCount = 0;
    int passCount  = 0;

    int mMode, mIndex, mExp, mMatch, mMiss, mErr;
    bit mLegal, mIdxValid, mWrap, mSeqErr;

    typedef struct {
        logic [7:0] code;
        logic       valid;
        logic [3:0] idx;
        logic       iv;
        logic       lg;
        logic       lk;
        logic       wr;
        logic       se;
        logic [7:0] ec;
    } vec_t;

    vec_t dirVecs[22];

    johnson_decoder #(
        .W(W), .IW(IW), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .code(code),
        .code_valid(codeValid),
        .index(index),
        .index_valid(indexValid),
        .legal(legal),
        .locked(locked),
        .wrap(wrap),
        .seq_err(seqErr),
        .err_count(errCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Johnson code of phase p: p ones from the LSB for the first half, then zeros fill from the LSB.
    function automatic int johnsonCode(input int p);
        if (p <= W) return (1 << p) - 1;
        return (1 << W) - (1 << (p - W));
    endfunction

    function automatic logic [16:0] dutPack();
        return {index, indexValid, legal, locked, wrap, seqErr, errCount};
    endfunction

    function automatic logic [16:0] modelPack();
        return {4'(mIndex), mIdxValid, mLegal, (mMode == MODE_LOCKED), mWrap, mSeqErr, 8'(mErr)};
    endfunction

    task automatic modelReset();
        mMode = MODE_HUNT; mIndex = 0; mExp = 0; mMatch = 0; mMiss = 0; mErr = 0;
        mLegal = 0; mIdxValid = 0; mWrap = 0; mSeqErr = 0;
    endtask

    task automatic modelStep(input logic [7:0] c, input logic v);
        bit lg;
        int k;
        lg = 0;
        k = 0;
        mIdxValid = v;
        mWrap = 0;
        mSeqErr = 0;
        if (!v) return;
        for (int p = 0; p < SEQ_LEN; p++) begin
            if (johnsonCode(p) == int'(c)) begin
                lg = 1;
                k = p;
            end
        end
        mLegal = lg;
        if (lg) mIndex = k;
        case (mMode)
            MODE_HUNT: if (lg) begin
                mExp = (k + 1) % SEQ_LEN;
                mMatch = 0;
                mMode = MODE_VERIFY;
            end
            MODE_VERIFY: begin
                if (!lg) mMode = MODE_HUNT;
                else if (k == mExp) begin
                    mMatch++;
                    mExp = (k + 1) % SEQ_LEN;
                    if (mMatch == LOCK_CNT) begin
                        mMode = MODE_LOCKED;
                        mMiss = 0;
                    end
                end else begin
                    mMatch = 0;
                    mExp = (k + 1) % SEQ_LEN;
                end
            end
            default: begin
                if (lg && k == mExp) begin
                    mMiss = 0;
                    mWrap = (k == 0);
                    mExp = (k + 1) % SEQ_LEN;
                end else begin
                    mSeqErr = 1;
                    if (mErr < 255) mErr++;
                    mMiss++;
                    mExp = lg ? (k + 1) % SEQ_LEN : (mExp + 1) % SEQ_LEN;
                    if (mMiss == MISS_MAX) mMode = MODE_HUNT;
                end
            end
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [16:0] actual, input logic [16:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got {idx,iv,lg,lk,wr,se,ec}=%h, expected %h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] c, input logic v, input string name);
        code = c;
        codeValid = v;
        @(posedge clk);
        modelStep(c, v);
        #1;
        checkOutput(name, dutPack(), modelPack());
    endtask

    task automatic doReset();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset", dutPack(), 17'h0);
        modelReset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        codeValid = 1'b0;
        #3;
    endtask

    initial begin
        int ph;
        int r;
        logic [7:0] rc;
        reset = 1'b0;
        code = '0;
        codeValid = 1'b0;
        modelReset();

        dirVecs[0]  = '{8'b00000101, 1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        dirVecs[1]  = '{8'b00000011, 1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        dirVecs[2]  = '{8'b01010101, 1'b1, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        dirVecs[3]  = '{8'b00000001, 1'b1, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        dirVecs[4]  = '{8'b00000011, 1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        dirVecs[5]  = '{8'b00000111, 1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        dirVecs[6]  = '{8'b00001111, 1'b1, 4'd4,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
        dirVecs[7]  = '{8'b00111111, 1'b1, 4'd6,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
        dirVecs[8]  = '{8'b01111111, 1'b1, 4'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        dirVecs[9]  = '{8'b00000000, 1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2};
        dirVecs[10] = '{8'b11111111, 1'b1, 4'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3};
        dirVecs[11] = '{8'b11111110, 1'b1, 4'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
        dirVecs[12] = '{8'b11111100, 1'b1, 4'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3};
        dirVecs[13] = '{8'b11111000, 1'b1, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        dirVecs[14] = '{8'b10101010, 1'b0, 4'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        dirVecs[15] = '{8'b11110000, 1'b1, 4'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        dirVecs[16] = '{8'b11100000, 1'b1, 4'd13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        dirVecs[17] = '{8'b11000000, 1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        dirVecs[18] = '{8'b10000000, 1'b1, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
        dirVecs[19] = '{8'b00000000, 1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3};
        dirVecs[20] = '{8'b01111110, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4};
        dirVecs[21] = '{8'b00000011, 1'b1, 4'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("power-on reset", dutPack(), 17'h0);
        #2;
        reset = 1'b1;
        #3;

        for (int i = 0; i < 22; i++) begin
            applyStimulus(dirVecs[i].code, dirVecs[i].valid, $sformatf("directed model %0d", i));
            checkOutput($sformatf("directed vec %0d", i), dutPack(),
                        {dirVecs[i].idx, dirVecs[i].iv, dirVecs[i].lg, dirVecs[i].lk,
                         dirVecs[i].wr, dirVecs[i].se, dirVecs[i].ec});
        end

        // Mid-lock reset, then idle cycles must keep every output at zero.
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'($urandom), 1'b0, "idle after reset");
            checkOutput("idle zero", dutPack(), 17'h0);
        end

        for (int i = 0; i <= SEQ_LEN; i++) begin
            applyStimulus(8'(johnsonCode(i % SEQ_LEN)), 1'b1, "sweep model");
            checkOutput($sformatf("sweep %0d", i), dutPack(),
                        {4'(i % SEQ_LEN), 1'b1, 1'b1, (i >= 2), (i == SEQ_LEN), 1'b0, 8'd0});
        end

        doReset();
        ph = 0;
        for (int round = 0; round < 150; round++) begin
            for (int j = 0; j < 3; j++) begin
                applyStimulus(8'(johnsonCode((ph + j) % SEQ_LEN)), 1'b1, "sat relock");
            end
            applyStimulus(8'(johnsonCode((ph + 5) % SEQ_LEN)), 1'b1, "sat miss 1");
            if (codeValid) codeValid = 1'b0;
            applyStimulus(8'hA5, 1'b0, "sat gap");
            applyStimulus(8'(johnsonCode((ph + 9) % SEQ_LEN)), 1'b1, "sat miss 2");
            ph = (ph + 10) % SEQ_LEN;
        end
        checkOutput("saturated err_count", {9'h0, errCount}, {9'h0, 8'd255});
        checkOutput("unlocked after sat", {16'h0, locked}, 17'h0);

        ph = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) begin
                doReset();
            end
            r = $urandom_range(0, 99);
            if (r < 70) begin
                ph = (ph + 1) % SEQ_LEN;
                applyStimulus(8'(johnsonCode(ph)), 1'b1, "random seq");
            end else if (r < 80) begin
                ph = $urandom_range(0, SEQ_LEN - 1);
                applyStimulus(8'(johnsonCode(ph)), 1'b1, "random jump");
            end else if (r < 90) begin
                rc = 8'($urandom);
                applyStimulus(rc, 1'b1, "random byte");
            end else begin
                applyStimulus(8'($urandom), 1'b0, "random gap");
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
